// File: rtl/blink_pkg.sv
// Shared types and sizing helpers for the LED blink scheduler.
package blink_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ON = 2'd1, OFF = 2'd2} sched_state_t;

  localparam int COUNT_W = 8;

  function automatic int tick_div(input int f_clk_hz);
    return f_clk_hz / 1000;
  endfunction

  function automatic int ms_w(input int max_ms);
    return $clog2(max_ms + 1);
  endfunction
endpackage

// File: rtl/blink_sched_if.sv
// Request/status bundle between status sources and the LED scheduler.
interface blink_sched_if #(
  parameter int N_REQ = 4,
  parameter int MS_W  = 10
);
  logic [N_REQ-1:0]                       req;
  logic [N_REQ-1:0][MS_W-1:0]             req_on_ms;
  logic [N_REQ-1:0][MS_W-1:0]             req_off_ms;
  logic [N_REQ-1:0][blink_pkg::COUNT_W-1:0] req_count;
  logic                                   led;
  logic [N_REQ-1:0]                       grant;
  logic                                   busy;
  logic [N_REQ-1:0]                       done;

  modport master (output req, req_on_ms, req_off_ms, req_count,
                  input  led, grant, busy, done);
  modport slave  (input  req, req_on_ms, req_off_ms, req_count,
                  output led, grant, busy, done);
endinterface

// File: rtl/ms_tick_gen.sv
// Millisecond prescaler; clr restarts the count so every phase starts on a full ms.
module ms_tick_gen #(
  parameter int DIV = 25000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CW'(DIV - 1));

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clr || tick) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/blink_sched.sv
// Fixed-priority LED sharer: grants one requester and sequences its ON/OFF blink pattern.
module blink_sched #(
  parameter int F_CLK_HZ = 25_000_000,
  parameter int N_REQ    = 4,
  parameter int MAX_MS   = 1000
) (
  input logic        clk,
  input logic        rst_n,
  blink_sched_if.slave bus
);
  import blink_pkg::*;

  localparam int TICK_DIV = tick_div(F_CLK_HZ);
  localparam int MS_W     = ms_w(MAX_MS);
  localparam int IDX_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  sched_state_t       state_q, state_d;
  logic [MS_W-1:0]    on_q, on_d, off_q, off_d, ms_q, ms_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d, rem_q, rem_d;
  logic [N_REQ-1:0]   grant_q, grant_d, done_q, done_d;
  logic               led_q, led_d, busy_q, busy_d;

  logic               tick, clr, phase_end, load;
  logic [MS_W-1:0]    sel, len;
  logic [IDX_W-1:0]   pick;
  logic               any_req, keep, preempt;

  ms_tick_gen #(.DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .tick  (tick)
  );

  always_comb begin
    pick = '0;
    for (int i = N_REQ - 1; i >= 0; i--)
      if (bus.req[i]) pick = IDX_W'(i);
  end

  assign any_req = |bus.req;
  // grant is one-hot, so grant-1 masks exactly the higher-priority indices
  assign preempt = |(bus.req & (grant_q - N_REQ'(1)));
  assign keep    = |(bus.req & grant_q);

  assign sel       = (state_q == OFF) ? off_q : on_q;
  assign len       = (sel == '0) ? MS_W'(1) : sel;
  assign phase_end = (state_q != IDLE) && tick && (ms_q == len - MS_W'(1));
  assign clr       = (state_q == IDLE) || phase_end;

  always_comb begin
    state_d = state_q;
    on_d    = on_q;
    off_d   = off_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    grant_d = grant_q;
    led_d   = led_q;
    busy_d  = busy_q;
    done_d  = '0;
    load    = 1'b0;
    ms_d    = clr ? '0 : (tick ? ms_q + MS_W'(1) : ms_q);

    unique case (state_q)
      IDLE: load = any_req;
      ON: if (phase_end) begin
        state_d = OFF;
        led_d   = 1'b0;
      end
      OFF: if (phase_end) begin
        if (cnt_q != '0) begin
          rem_d = rem_q - COUNT_W'(1);
          if (rem_q > COUNT_W'(1)) begin
            state_d = ON;
            led_d   = 1'b1;
          end else begin
            state_d = IDLE;
            done_d  = grant_q;
            grant_d = '0;
            busy_d  = 1'b0;
          end
        end else if (preempt) begin
          load = 1'b1;
        end else if (keep) begin
          state_d = ON;
          led_d   = 1'b1;
        end else begin
          state_d = IDLE;
          grant_d = '0;
          busy_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      state_d = ON;
      led_d   = 1'b1;
      busy_d  = 1'b1;
      grant_d = N_REQ'(1) << pick;
      on_d    = bus.req_on_ms[pick];
      off_d   = bus.req_off_ms[pick];
      cnt_d   = bus.req_count[pick];
      rem_d   = bus.req_count[pick];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      on_q    <= '0;
      off_q   <= '0;
      ms_q    <= '0;
      cnt_q   <= '0;
      rem_q   <= '0;
      grant_q <= '0;
      done_q  <= '0;
      led_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      on_q    <= on_d;
      off_q   <= off_d;
      ms_q    <= ms_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      led_q   <= led_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.led   = led_q;
  assign bus.grant = grant_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
endmodule
